// File: rtl/pipeline_hazard_sequencer.sv
// rtl/pipeline_hazard_sequencer.sv - stall/flush sequencer for the 5-stage pipeline
// Combinational stage enables/flushes from redirect, load-use and memory-wait hazards.
module pipeline_hazard_sequencer #(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int MEM_TIMEOUT      = 64,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       pc_selection,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             dmem_req,
  input  logic             dmem_done,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             id_ex_write_en,
  output logic             ex_mem_write_en,
  output logic             mem_wb_write_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [3:0]        BUB_LOAD = 4'(REDIRECT_BUBBLES);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  state_t            state_q, state_d, ret_state_q, ret_state_d, eff_state;
  logic [3:0]        bub_cnt_q, bub_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]  flush_events_q, flush_events_d;

  logic mem_stall, redirect, load_use;

  assign mem_stall = dmem_req & ~dmem_done;
  assign redirect  = (pc_selection != 2'b00);
  assign load_use  = ex_mem_read & (ex_rd != 5'd0) &
                     ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

  // Leaving MEM_WAIT resolves to the saved state in the same cycle, so no dead cycle.
  assign eff_state = (state_q == MEM_WAIT) ? ret_state_q : state_q;

  always_comb begin
    state_d         = state_q;
    ret_state_d     = ret_state_q;
    bub_cnt_d       = bub_cnt_q;
    wait_cnt_d      = wait_cnt_q;
    mem_timeout_d   = mem_timeout_q;
    stall_cycles_d  = stall_cycles_q;
    flush_events_d  = flush_events_q;
    pc_write_en     = 1'b1;
    if_id_write_en  = 1'b1;
    id_ex_write_en  = 1'b1;
    ex_mem_write_en = 1'b1;
    mem_wb_write_en = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;

    if (mem_stall) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
      mem_wb_write_en = 1'b0;
      if (state_q != MEM_WAIT) begin
        ret_state_d = state_q;
        state_d     = MEM_WAIT;
      end
      if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
      if (wait_cnt_d == WAIT_MAX) mem_timeout_d = 1'b1;
      if (stall_cycles_q != CNT_MAX) stall_cycles_d = stall_cycles_q + 1'b1;
    end else begin
      wait_cnt_d = '0;
      state_d    = eff_state;
      if (redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        bub_cnt_d   = BUB_LOAD;
        state_d     = (BUB_LOAD != 4'd0) ? FLUSH : RUN;
        if (flush_events_q != CNT_MAX) flush_events_d = flush_events_q + 1'b1;
      end else if (eff_state == FLUSH) begin
        // ID holds a bubble here, so a load-use match cannot be real.
        if_id_flush = 1'b1;
        bub_cnt_d   = bub_cnt_q - 1'b1;
        if (bub_cnt_q == 4'd1) state_d = RUN;
      end else if (load_use) begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        id_ex_flush    = 1'b1;
        if (stall_cycles_q != CNT_MAX) stall_cycles_d = stall_cycles_q + 1'b1;
      end
    end

    if (rst) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
      mem_wb_write_en = 1'b0;
      if_id_flush     = 1'b1;
      id_ex_flush     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      ret_state_q    <= RUN;
      bub_cnt_q      <= '0;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      state_q        <= state_d;
      ret_state_q    <= ret_state_d;
      bub_cnt_q      <= bub_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// tb/tb_pipeline_hazard_sequencer.sv - directed + random bench for pipeline_hazard_sequencer
// Reference tracks only bubbles left, wait run length, sticky timeout and counters.
module tb_pipeline_hazard_sequencer;
  localparam int RB    = 1;
  localparam int MT    = 8;
  localparam int CW    = 6;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    pc_selection;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_mem_read, dmem_req, dmem_done;
  logic          pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en, mem_wb_write_en;
  logic          if_id_flush, id_ex_flush, mem_timeout;
  logic [CW-1:0] stall_cycles, flush_events;

  int total = 0;
  int bad   = 0;

  // reference state
  int m_bubbles = 0, m_wait = 0, m_stall = 0, m_flush = 0;
  bit m_timeout = 0;

  pipeline_hazard_sequencer #(.REDIRECT_BUBBLES(RB), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .pc_selection(pc_selection),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .dmem_req(dmem_req), .dmem_done(dmem_done),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en), .id_ex_write_en(id_ex_write_en),
    .ex_mem_write_en(ex_mem_write_en), .mem_wb_write_en(mem_wb_write_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ctl();
    return {pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en, mem_wb_write_en,
            if_id_flush, id_ex_flush};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare every cycle at the falling edge, then advance the reference as the rising edge will.
  always @(negedge clk) begin
    bit ms, rd, lu;
    logic [6:0] exp_ctl;
    ms = dmem_req && !dmem_done;
    rd = pc_selection != 0;
    lu = ex_mem_read && ex_rd != 0 &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (rst)               exp_ctl = 7'b0000011;
    else if (ms)           exp_ctl = 7'b0000000;
    else if (rd)           exp_ctl = 7'b1111111;
    else if (m_bubbles > 0) exp_ctl = 7'b1111110;
    else if (lu)           exp_ctl = 7'b0011101;
    else                   exp_ctl = 7'b1111100;
    chk("model_ctl", int'(ctl()), int'(exp_ctl));
    chk("model_timeout", int'(mem_timeout), int'(m_timeout));
    chk("model_stall_cycles", int'(stall_cycles), m_stall);
    chk("model_flush_events", int'(flush_events), m_flush);

    if (rst) begin
      m_bubbles = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_timeout = 0;
    end else if (ms) begin
      if (m_wait < MT) m_wait++;
      if (m_wait >= MT) m_timeout = 1;
      if (m_stall < CMAX) m_stall++;
    end else begin
      m_wait = 0;
      if (rd) begin
        m_bubbles = RB;
        if (m_flush < CMAX) m_flush++;
      end else if (m_bubbles > 0) m_bubbles--;
      else if (lu && m_stall < CMAX) m_stall++;
    end
  end

  task automatic idle();
    pc_selection = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_mem_read = 0; ex_rd = 0; dmem_req = 0; dmem_done = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; idle();
    #1;
    chk("rst_ctl", int'(ctl()), 7'b0000011);
    step(); step(); step();
    rst = 0; #1;
    chk("run_ctl", int'(ctl()), 7'b1111100);
    chk("run_stall0", int'(stall_cycles), 0);
    chk("run_flush0", int'(flush_events), 0);

    // load-use hit, then ex_rd=0 is not a hazard
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1; #1;
    chk("lu_ctl", int'(ctl()), 7'b0011101);
    step(); idle(); #1;
    chk("lu_stall", int'(stall_cycles), 1);
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1; #1;
    chk("lu_x0_ctl", int'(ctl()), 7'b1111100);
    step(); idle(); #1;
    chk("lu_x0_stall", int'(stall_cycles), 1);

    // redirect with one bubble
    pc_selection = 2'b01; #1;
    chk("rd_c0", int'(ctl()), 7'b1111111);
    step(); idle(); #1;
    chk("rd_c1", int'(ctl()), 7'b1111110);
    chk("rd_events", int'(flush_events), 1);
    step(); #1;
    chk("rd_c2", int'(ctl()), 7'b1111100);

    // four frozen cycles
    dmem_req = 1; dmem_done = 0;
    for (int i = 0; i < 4; i++) begin
      #1; chk("mw_freeze", int'(ctl()), 0);
      step();
    end
    dmem_done = 1; #1;
    chk("mw_release", int'(ctl()), 7'b1111100);
    chk("mw_stall", int'(stall_cycles), 5);
    step(); idle();

    // memory wait inside the post-redirect bubble
    pc_selection = 2'b10; step(); idle();
    dmem_req = 1; step(); step();
    dmem_done = 1; #1;
    chk("mw_flush_resume", int'(ctl()), 7'b1111110);
    step(); idle(); #1;
    chk("mw_flush_after", int'(ctl()), 7'b1111100);

    // watchdog
    dmem_req = 1; dmem_done = 0;
    for (int i = 1; i <= 10; i++) begin
      #1; chk("wd_flag", int'(mem_timeout), (i >= 9) ? 1 : 0);
      step();
    end
    idle(); step(); #1;
    chk("wd_sticky", int'(mem_timeout), 1);

    // redirect beats load-use
    begin
      int s0;
      s0 = int'(stall_cycles);
      pc_selection = 2'b11; ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 1; #1;
      chk("rd_lu_ctl", int'(ctl()), 7'b1111111);
      step(); idle(); #1;
      chk("rd_lu_stall", int'(stall_cycles), s0);
    end

    // reset mid-bubble
    pc_selection = 2'b01; step(); idle();
    rst = 1; step(); rst = 0; #1;
    chk("rst_flush_ctl", int'(ctl()), 7'b1111100);
    chk("rst_timeout", int'(mem_timeout), 0);

    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 499) == 0);
      pc_selection = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      dmem_req     = ($urandom_range(0, 2) == 0);
      dmem_done    = ($urandom_range(0, 2) == 0);
      ex_mem_read  = 1'($urandom_range(0, 1));
      ex_rd        = 5'($urandom_range(0, 5));
      id_rs1       = 5'($urandom_range(0, 5));
      id_rs2       = 5'($urandom_range(0, 5));
      id_uses_rs1  = 1'($urandom_range(0, 1));
      id_uses_rs2  = 1'($urandom_range(0, 1));
      step();
    end
    idle(); rst = 0;
    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
